// File: rtl/ais_rx_ctrl.sv
// AIS receive-frame controller: bit counting, LSB-first byte packing, length and optional FCS check.
// Optional feature: define AIS_RX_CRC_CHECK_EN to build the serial CRC-16/X.25 check.
module ais_rx_ctrl #(
   parameter int FRAME_BITS = 184,
   parameter int MAX_BITS   = 256
) (
   input  logic       sclk,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       bit_vld,
   input  logic       flag_start,
   input  logic       flag_end,
   input  logic       frame_ack,
   output logic [7:0] byte_data,
   output logic [4:0] byte_addr,
   output logic       byte_wr,
   output logic       frame_done,
   output logic       frame_ok,
   output logic [8:0] nbits,
   output logic       frame_err,
   output logic [7:0] drop_cnt,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_HOLD} state_t;

   localparam logic [8:0] FRAME_CNT = 9'(FRAME_BITS);
   localparam logic [8:0] MAX_CNT   = 9'(MAX_BITS);

   state_t     state;
   logic [8:0] cnt;
   logic [7:0] sr;
   logic [7:0] sr_nxt;
   logic [8:0] cnt_nxt;
   logic       start_rx;
   logic       take_bit;
   logic       crc_ok;

   // A start flag opens a new frame from IDLE, resyncs inside RECV, or follows an ack in HOLD.
   assign start_rx = flag_start && (state == S_IDLE || state == S_RECV ||
                                    (state == S_HOLD && frame_ack));
   assign take_bit = (state == S_RECV) && !flag_start && bit_vld;
   assign sr_nxt   = {bit_in, sr[7:1]};
   assign cnt_nxt  = cnt + 9'd1;

`ifdef AIS_RX_CRC_CHECK_EN
   logic [15:0] crc;
   logic [15:0] crc_nxt;

   // NOTE: default assignment first so the combinational block never infers a latch.
   always_comb begin
      crc_nxt = {1'b0, crc[15:1]};
      if (crc[0] ^ bit_in) crc_nxt = crc_nxt ^ 16'h8408;
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n)        crc <= 16'hFFFF;
      else if (start_rx) crc <= 16'hFFFF;
      else if (take_bit) crc <= crc_nxt;
   end

   // Running the register over data plus complemented FCS leaves the fixed X.25 residue.
   assign crc_ok = (crc == 16'hF0B8);
`else
   assign crc_ok = 1'b1;
`endif

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         sr         <= '0;
         byte_data  <= '0;
         byte_addr  <= '0;
         byte_wr    <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         nbits      <= '0;
         frame_err  <= 1'b0;
         drop_cnt   <= '0;
         busy       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         byte_wr   <= 1'b0;
         frame_err <= 1'b0;
         if (start_rx) begin
            cnt   <= '0;
            sr    <= '0;
            state <= S_RECV;
            busy  <= 1'b1;
         end
         case (state)
            S_IDLE: ;
            S_RECV: begin
               if (flag_start) begin
                  frame_err <= 1'b1;
               end else begin
                  if (bit_vld) begin
                     sr  <= sr_nxt;
                     cnt <= cnt_nxt;
                     if (cnt_nxt[2:0] == 3'd0) begin
                        byte_wr   <= 1'b1;
                        byte_data <= sr_nxt;
                        byte_addr <= cnt[7:3];
                     end
                  end
                  if (flag_end) begin
                     state <= S_CHECK;
                  end else if (bit_vld && cnt_nxt == MAX_CNT) begin
                     frame_err <= 1'b1;
                     state     <= S_IDLE;
                     busy      <= 1'b0;
                  end
               end
            end
            S_CHECK: begin
               nbits      <= cnt;
               frame_ok   <= (cnt == FRAME_CNT) && crc_ok;
               frame_done <= 1'b1;
               state      <= S_HOLD;
            end
            S_HOLD: begin
               if (frame_ack) begin
                  frame_done <= 1'b0;
                  if (!flag_start) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else if (flag_start && drop_cnt != 8'hFF) begin
                  drop_cnt <= drop_cnt + 8'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ais_rx_ctrl.sv
// Self-checking bench for ais_rx_ctrl: table of frame vectors plus directed multi-cycle sequences.
module tb_ais_rx_ctrl;

   logic       sclk = 1'b0;
   logic       rst_n;
   logic       bit_in, bit_vld, flag_start, flag_end, frame_ack;
   logic [7:0] byte_data;
   logic [4:0] byte_addr;
   logic       byte_wr, frame_done, frame_ok, frame_err, busy;
   logic [8:0] nbits;
   logic [7:0] drop_cnt;

`ifdef AIS_RX_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   ais_rx_ctrl dut (
      .sclk(sclk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
      .flag_start(flag_start), .flag_end(flag_end), .frame_ack(frame_ack),
      .byte_data(byte_data), .byte_addr(byte_addr), .byte_wr(byte_wr),
      .frame_done(frame_done), .frame_ok(frame_ok), .nbits(nbits),
      .frame_err(frame_err), .drop_cnt(drop_cnt), .busy(busy)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      int len;
      int flip;
      bit end_last;
      int exp_ok;
      int exp_wr;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   int         wr_n, err_n, done_n;
   logic [7:0] wr_data[64];
   logic [4:0] wr_addr[64];
   logic       fb[512];
   vec_t       vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_n = 0; err_n = 0; done_n = 0;
   endtask

   // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge sclk);
      #1;
      if (byte_wr) begin
         if (wr_n < 64) begin
            wr_data[wr_n] = byte_data;
            wr_addr[wr_n] = byte_addr;
         end
         wr_n++;
      end
      if (frame_err)  err_n++;
      if (frame_done) done_n++;
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic [15:0] r;
      r = c >> 1;
      if (c[0] ^ b) r = r ^ 16'h8408;
      return r;
   endfunction

   task automatic build_good();
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < 168; i++) begin
         fb[i] = 1'($urandom_range(0, 1));
         c = crc_step(c, fb[i]);
      end
      c = ~c;
      for (int i = 0; i < 16; i++) fb[168 + i] = c[i];
   endtask

   task automatic build_rand(input int n);
      for (int i = 0; i < n; i++) fb[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic pulse_start();
      flag_start = 1'b1;
      tick();
      flag_start = 1'b0;
   endtask

   task automatic send_bits(input int n, input bit end_on_last);
      for (int i = 0; i < n; i++) begin
         bit_vld = 1'b1;
         bit_in  = fb[i];
         if (end_on_last && i == n - 1) flag_end = 1'b1;
         tick();
         bit_vld  = 1'b0;
         flag_end = 1'b0;
         if (i % 7 == 3 && i != n - 1) begin
            bit_in = ~fb[i];
            tick();
         end
      end
   endtask

   task automatic close_and_check(input string tag, input bit end_on_last,
                                  input int exp_ok, input int exp_nbits, input int exp_wr);
      logic [7:0] eb;
      int         wr_before;
      if (!end_on_last) begin
         flag_end = 1'b1;
         tick();
         flag_end = 1'b0;
      end
      check({tag, "_done_n1"}, frame_done, 0);
      check({tag, "_busy_chk"}, busy, 1);
      tick();
      check({tag, "_done_n2"}, frame_done, 1);
      check({tag, "_ok"}, frame_ok, exp_ok);
      check({tag, "_nbits"}, nbits, exp_nbits);
      check({tag, "_wr_cnt"}, wr_n, exp_wr);
      for (int k = 0; k < exp_wr && k < wr_n && k < 64; k++) begin
         for (int j = 0; j < 8; j++) eb[j] = fb[8 * k + j];
         check({tag, "_wr_addr"}, wr_addr[k], k);
         check({tag, "_wr_data"}, wr_data[k], eb);
      end
      check({tag, "_no_err"}, err_n, 0);
      wr_before = wr_n;
      bit_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bit_in = ~bit_in;
         tick();
      end
      bit_vld = 1'b0;
      check({tag, "_hold_done"}, frame_done, 1);
      check({tag, "_hold_nowr"}, wr_n, wr_before);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check({tag, "_ack_done"}, frame_done, 0);
      check({tag, "_ack_busy"}, busy, 0);
      check({tag, "_ok_stable"}, frame_ok, exp_ok);
      check({tag, "_nbits_stable"}, nbits, exp_nbits);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_byte_data"}, byte_data, 0);
      check({tag, "_byte_addr"}, byte_addr, 0);
      check({tag, "_byte_wr"}, byte_wr, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_frame_ok"}, frame_ok, 0);
      check({tag, "_nbits"}, nbits, 0);
      check({tag, "_frame_err"}, frame_err, 0);
      check({tag, "_drop_cnt"}, drop_cnt, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      vecs[0] = '{len: 184, flip: -1,  end_last: 1'b0, exp_ok: 1,       exp_wr: 23};
      vecs[1] = '{len: 184, flip: 175, end_last: 1'b0, exp_ok: !CRC_EN, exp_wr: 23};
      vecs[2] = '{len: 184, flip: 50,  end_last: 1'b1, exp_ok: !CRC_EN, exp_wr: 23};
      vecs[3] = '{len: 100, flip: -1,  end_last: 1'b0, exp_ok: 0,       exp_wr: 12};
      vecs[4] = '{len: 184, flip: -1,  end_last: 1'b1, exp_ok: 1,       exp_wr: 23};
      vecs[5] = '{len: 192, flip: -1,  end_last: 1'b0, exp_ok: 0,       exp_wr: 24};
      vecs[6] = '{len: 176, flip: -1,  end_last: 1'b1, exp_ok: 0,       exp_wr: 22};

      rst_n = 1'b0; bit_in = 1'b0; bit_vld = 1'b0;
      flag_start = 1'b0; flag_end = 1'b0; frame_ack = 1'b0;
      clear_log();
      tick(); tick();
      check_reset_outs("reset");
      rst_n = 1'b1;
      tick();

      // Table of complete frames.
      for (int v = 0; v < 7; v++) begin
         clear_log();
         if (vecs[v].len == 184) build_good();
         else build_rand(vecs[v].len);
         if (vecs[v].flip >= 0) fb[vecs[v].flip] = ~fb[vecs[v].flip];
         pulse_start();
         check($sformatf("vec%0d_busy_start", v), busy, 1);
         send_bits(vecs[v].len, vecs[v].end_last);
         close_and_check($sformatf("vec%0d", v), vecs[v].end_last,
                         vecs[v].exp_ok, vecs[v].len, vecs[v].exp_wr);
         tick();
      end

      // Runaway frame: abort on the 256th bit.
      clear_log();
      build_rand(256);
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         bit_vld = 1'b1;
         bit_in  = fb[i];
         tick();
      end
      bit_vld = 1'b0;
      check("runaway_err_pulse", frame_err, 1);
      check("runaway_busy", busy, 0);
      tick();
      check("runaway_err_clear", frame_err, 0);
      flag_end = 1'b1;
      tick();
      flag_end = 1'b0;
      tick(); tick();
      check("runaway_err_cnt", err_n, 1);
      check("runaway_no_done", done_n, 0);
      check("runaway_wr_cnt", wr_n, 32);
      check("runaway_last_addr", wr_addr[31], 31);

      // Resync: second flag_start after 40 bits, then a good frame.
      clear_log();
      pulse_start();
      for (int i = 0; i < 40; i++) begin
         bit_vld = 1'b1;
         bit_in  = 1'($urandom_range(0, 1));
         tick();
         if (i == 6) check("resync_no_wr_bit7", byte_wr, 0);
         if (i == 7) check("resync_wr_bit8", byte_wr, 1);
      end
      bit_vld = 1'b0;
      check("resync_pre_wr", wr_n, 5);
      pulse_start();
      check("resync_err", frame_err, 1);
      check("resync_busy", busy, 1);
      clear_log();
      tick();
      check("resync_err_clear", frame_err, 0);
      build_good();
      send_bits(184, 1'b0);
      close_and_check("resync", 1'b0, 1, 184, 23);

      // Drops while a result is pending.
      clear_log();
      build_good();
      pulse_start();
      send_bits(184, 1'b0);
      flag_end = 1'b1;
      tick();
      flag_end = 1'b0;
      tick();
      for (int p = 0; p < 3; p++) begin
         flag_start = 1'b1;
         bit_vld    = 1'b1;
         tick();
         flag_start = 1'b0;
         bit_vld    = 1'b0;
         check("drop_done_held", frame_done, 1);
         tick();
      end
      check("drop_cnt3", drop_cnt, 3);
      check("drop_no_wr", wr_n, 23);
      frame_ack  = 1'b1;
      flag_start = 1'b1;
      tick();
      frame_ack  = 1'b0;
      flag_start = 1'b0;
      clear_log();
      check("ackstart_done", frame_done, 0);
      check("ackstart_busy", busy, 1);
      check("ackstart_drop", drop_cnt, 3);
      build_rand(100);
      send_bits(100, 1'b0);
      close_and_check("ackstart", 1'b0, 0, 100, 12);

      // Drop counter saturation.
      build_rand(16);
      pulse_start();
      send_bits(16, 1'b0);
      flag_end = 1'b1;
      tick();
      flag_end = 1'b0;
      tick();
      for (int p = 0; p < 260; p++) begin
         pulse_start();
         tick();
      end
      check("drop_sat", drop_cnt, 255);
      check("drop_sat_done", frame_done, 1);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check("drop_sat_ack", frame_done, 0);

      // frame_ack outside HOLD is ignored.
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check("idle_ack_busy", busy, 0);
      check("idle_ack_drop", drop_cnt, 255);

      // Reset asserted mid-RECV.
      clear_log();
      build_rand(12);
      pulse_start();
      send_bits(12, 1'b0);
      check("rst_pre_wr", wr_n, 1);
      @(posedge sclk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outs("rst_async");
      bit_vld = 1'b1;
      tick(); tick();
      check_reset_outs("rst_held");
      bit_vld = 1'b0;
      rst_n   = 1'b1;
      tick();
      clear_log();
      build_rand(8);
      send_bits(8, 1'b0);
      tick();
      check("idle_bits_ignored", wr_n, 0);
      check_reset_outs("rst_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
